// File: rtl/preio_rx_pkg.sv
// preio_rx_pkg: shared types and helpers for the PREIO receive deserializer.
package preio_rx_pkg;

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_e;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/preio_rx_fifo2.sv
// preio_rx_fifo2: 2-entry first-word-fall-through FIFO with drop-on-full indication.
module preio_rx_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wp_q, rp_q;
    logic [1:0]       cnt_q;
    logic             full, pop, wr;

    assign full    = cnt_q == 2'd2;
    assign empty_o = cnt_q == 2'd0;
    assign pop     = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr      = push_i & (~full | pop);
    assign drop_o  = push_i & full & ~pop;
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk_i) begin
        if (rst_i | flush_i) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (wr) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, wr} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/preio_rx_deser.sv
// preio_rx_deser: synchronizes the pad serial stream, locks onto sync words and
// delivers framed MSB-first data words through a 2-entry FIFO.
module preio_rx_deser
    import preio_rx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SYNC_WORD_DEF),
    parameter int               FRAME_LEN   = 16,
    parameter int               ERR_LIMIT   = 2
) (
    input  logic             pad_clk,
    input  logic             pad_reset,
    input  logic             pad_inpad,
    input  logic             enable,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    output logic             locked,
    output logic             lost_lock,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int BW = cnt_w(WIDTH);
    localparam int WW = cnt_w(FRAME_LEN + 1);
    localparam int EW = cnt_w(ERR_LIMIT + 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [WIDTH-1:0]       sr_q, sr_d, push_data_q;
    logic [BW-1:0]          bit_q, bit_d;
    logic [WW-1:0]          word_q, word_d;
    logic [EW-1:0]          err_q, err_d;
    logic                   push_q, push_d, lost_q, lost_d, ovf_q, ovf_d;
    logic                   s, word_done, empty, drop;

    assign s         = sync_q[SYNC_STAGES-1];
    assign word_done = bit_q == BW'(WIDTH - 1);
    assign ovf_d     = drop | (ovf_q & ~overflow_clr);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        word_d  = word_q;
        err_d   = err_q;
        push_d  = 1'b0;
        lost_d  = 1'b0;
        sr_d    = (state_q == IDLE) ? sr_q : {sr_q[WIDTH-2:0], s};
        if (!enable) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = HUNT;
        end else if (state_q == HUNT) begin
            if (sr_d == SYNC_WORD) begin
                state_d = LOCKED;
                bit_d   = '0;
                word_d  = '0;
                err_d   = '0;
            end
        end else begin
            bit_d = word_done ? '0 : bit_q + 1'b1;
            if (word_done) begin
                if (word_q != WW'(FRAME_LEN)) begin
                    push_d = 1'b1;
                    word_d = word_q + 1'b1;
                end else if (sr_d == SYNC_WORD) begin
                    err_d  = '0;
                    word_d = '0;
                end else if (err_q != EW'(ERR_LIMIT - 1)) begin
                    err_d  = err_q + 1'b1;
                    word_d = '0;
                end else begin
                    state_d = HUNT;
                    lost_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pad_clk) begin
        if (pad_reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            sr_q        <= '0;
            bit_q       <= '0;
            word_q      <= '0;
            err_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            lost_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pad_inpad};
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            err_q       <= err_d;
            push_q      <= push_d;
            push_data_q <= sr_d;
            lost_q      <= lost_d;
            ovf_q       <= ovf_d;
        end
    end

    preio_rx_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk_i   (pad_clk),
        .rst_i   (pad_reset),
        .flush_i (~enable),
        .push_i  (push_q),
        .din_i   (push_data_q),
        .pop_i   (word_ready),
        .dout_o  (word_data),
        .empty_o (empty),
        .drop_o  (drop)
    );

    assign word_valid = ~empty;
    assign locked     = state_q == LOCKED;
    assign lost_lock  = lost_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_preio_rx_deser.sv
// tb_preio_rx_deser: random framed streams checked against a bit-stream scan model,
// plus directed backpressure, reset and enable cases.
module tb_preio_rx_deser;

    localparam int         W    = 8;
    localparam int         S    = 2;
    localparam int         F    = 16;
    localparam int         E    = 2;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       pad_clk = 1'b0;
    logic       pad_reset, pad_inpad, enable, word_ready, overflow_clr;
    logic [7:0] word_data;
    logic       word_valid, locked, lost_lock, overflow;

    int         checks = 0, errors = 0, cyc = 0, t0 = 0;
    bit         mon_on = 1'b0;
    bit         exp_lk;
    bit         b[$];
    logic [7:0] got_w[$], exp_w[$];
    int         got_c[$], exp_c[$], got_l[$], exp_l[$];

    preio_rx_deser #(
        .WIDTH(W), .SYNC_STAGES(S), .SYNC_WORD(SYNC), .FRAME_LEN(F), .ERR_LIMIT(E)
    ) dut (
        .pad_clk      (pad_clk),
        .pad_reset    (pad_reset),
        .pad_inpad    (pad_inpad),
        .enable       (enable),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .locked       (locked),
        .lost_lock    (lost_lock),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 pad_clk = ~pad_clk;

    always @(posedge pad_clk) cyc <= cyc + 1;

    always @(negedge pad_clk) begin
        if (mon_on) begin
            if (word_valid && word_ready) begin
                got_w.push_back(word_data);
                got_c.push_back(cyc - t0);
            end
            if (lost_lock) got_l.push_back(cyc - t0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pad_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        pad_reset = 1'b1;
        tick();
        pad_reset = 1'b0;
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) b.push_back(v[i]);
    endtask

    task automatic drive();
        foreach (b[j]) begin
            pad_inpad = b[j];
            tick();
        end
        b.delete();
        pad_inpad = 1'b0;
    endtask

    // Bit j reaches the shift register SYNC_STAGES cycles after it is driven;
    // a completed word is visible two cycles later, a lost-lock pulse one cycle later.
    function automatic void model(input int last);
        logic [7:0] win = '0;
        bit lk = 1'b0;
        int ph = 0, wc = 0, ec = 0;
        exp_w.delete();
        exp_c.delete();
        exp_l.delete();
        exp_lk = 1'b0;
        foreach (b[j]) begin
            win = {win[6:0], b[j]};
            if (!lk) begin
                if (win == SYNC) begin
                    lk = 1'b1;
                    ph = 0;
                    wc = 0;
                    ec = 0;
                end
            end else begin
                ph++;
                if (ph == W) begin
                    ph = 0;
                    if (wc < F) begin
                        if (j + S + 2 <= last) begin
                            exp_w.push_back(win);
                            exp_c.push_back(j + S + 2);
                        end
                        wc++;
                    end else if (win == SYNC) begin
                        wc = 0;
                        ec = 0;
                    end else if (ec + 1 < E) begin
                        ec++;
                        wc = 0;
                    end else begin
                        lk = 1'b0;
                        if (j + S + 1 <= last) exp_l.push_back(j + S + 1);
                    end
                end
            end
            if (j + S + 1 <= last + 1) exp_lk = lk;
        end
    endfunction

    task automatic run_stream(input string tag);
        int n;
        for (int i = 0; i < 12; i++) b.push_back(1'b0);
        model(b.size() - 1);
        do_reset();
        enable     = 1'b1;
        word_ready = 1'b1;
        pad_inpad  = 1'b0;
        tick(3);
        got_w.delete();
        got_c.delete();
        got_l.delete();
        t0     = cyc;
        mon_on = 1'b1;
        drive();
        mon_on = 1'b0;
        check({tag, "_nwords"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, got_w[i], exp_w[i]);
            check({tag, "_word_cycle"}, got_c[i], exp_c[i]);
        end
        check({tag, "_nlost"}, got_l.size(), exp_l.size());
        n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
        for (int i = 0; i < n; i++) check({tag, "_lost_cycle"}, got_l[i], exp_l[i]);
        check({tag, "_locked_end"}, locked, exp_lk);
    endtask

    task automatic lock_and_send3();
        do_reset();
        enable     = 1'b1;
        word_ready = 1'b0;
        pad_inpad  = 1'b0;
        tick(3);
        add_byte(SYNC);
        for (int i = 0; i < 3; i++) add_byte(8'(i));
        drive();
    endtask

    initial begin
        pad_reset    = 1'b1;
        pad_inpad    = 1'b0;
        enable       = 1'b0;
        word_ready   = 1'b0;
        overflow_clr = 1'b0;
        tick(2);
        check("rst_data", word_data, 0);
        check("rst_valid", word_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost_lock, 0);
        check("rst_ovf", overflow, 0);
        pad_reset = 1'b0;

        for (int i = 0; i < 20; i++) b.push_back(1'($urandom_range(0, 1)));
        add_byte(SYNC);
        for (int i = 0; i < F; i++) add_byte(8'(i));
        add_byte(SYNC);
        for (int i = 0; i < 4; i++) add_byte(8'(8'h40 + i));
        run_stream("lock");

        add_byte(SYNC);
        for (int i = 0; i < F; i++) add_byte(8'(8'h10 + i));
        add_byte(8'h5A);
        for (int i = 0; i < F; i++) add_byte(8'(8'h20 + i));
        add_byte(SYNC);
        for (int i = 0; i < F; i++) add_byte(8'(8'h30 + i));
        run_stream("fly");

        add_byte(SYNC);
        for (int i = 0; i < F; i++) add_byte(8'(i));
        add_byte(8'h5A);
        for (int i = 0; i < F; i++) add_byte(8'(8'h60 + i));
        add_byte(8'h3C);
        for (int i = 0; i < 4; i++) add_byte(8'h00);
        add_byte(SYNC);
        for (int i = 0; i < F; i++) add_byte(8'(8'h70 + i));
        run_stream("loss");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) b.push_back(1'($urandom_range(0, 1)));
            for (int f = 0; f < 4; f++) begin
                add_byte(($urandom_range(0, 3) != 0) ? SYNC : 8'($urandom));
                for (int i = 0; i < F; i++) add_byte(8'($urandom));
            end
            run_stream("rnd");
        end

        lock_and_send3();
        tick(3);
        check("ovf_set", overflow, 1);
        check("ovf_valid", word_valid, 1);
        check("ovf_head", word_data, 8'h00);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        word_ready = 1'b1;
        check("ovf_pop0", word_data, 8'h00);
        tick();
        check("ovf_pop1", word_data, 8'h01);
        tick();
        check("ovf_empty", word_valid, 0);
        word_ready = 1'b0;

        lock_and_send3();
        tick(2);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("fpp_ovf", overflow, 0);
        check("fpp_head1", word_data, 8'h01);
        word_ready = 1'b1;
        tick();
        check("fpp_head2", word_data, 8'h02);
        tick();
        check("fpp_empty", word_valid, 0);
        word_ready = 1'b0;

        do_reset();
        enable    = 1'b1;
        pad_inpad = 1'b0;
        tick(3);
        add_byte(SYNC);
        for (int i = 0; i < 7; i++) add_byte(8'(i));
        for (int i = 0; i < 4; i++) b.push_back(1'b0);
        drive();
        check("mid_locked", locked, 1);
        check("mid_ovf", overflow, 1);
        pad_reset = 1'b1;
        tick();
        pad_reset = 1'b0;
        check("mid_rst_data", word_data, 0);
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_lost", lost_lock, 0);
        check("mid_rst_ovf", overflow, 0);
        tick();
        check("mid_rst_hunt", locked, 0);

        lock_and_send3();
        tick(3);
        check("en_pre_valid", word_valid, 1);
        check("en_pre_locked", locked, 1);
        enable = 1'b0;
        tick();
        check("en_valid", word_valid, 0);
        check("en_locked", locked, 0);
        check("en_lost", lost_lock, 0);
        tick();
        check("en_lost2", lost_lock, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
